// File: rtl/multi_chan_timer_pkg.sv
// Shared constants for multi_chan_timer: channel FSM encoding, mode values
// and the start-edge helper used by every channel.
package multi_chan_timer_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // A channel starts only on a fresh rising edge of its enable.
    function automatic logic is_start(input logic en, input logic en_ff);
        return en & ~en_ff;
    endfunction

endpackage

// File: rtl/multi_chan_timer_ch.sv
// One down-counting timer channel: start on enable rising edge, one-shot or
// periodic reload from a shadow copy, hold freezes the count, low enable aborts.
module multi_chan_timer_ch
    import multi_chan_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             hold,
    input  logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] cnt,
    output logic             done,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             state;
    logic             mode_q;
    logic             en_ff;
    logic [CNT_W-1:0] shadow;
    logic             start;
    logic             cnt_zero;

    assign start    = is_start(en, en_ff);
    assign cnt_zero = (cnt == '0);
    assign expire   = (state == ST_RUN) & cnt_zero & ~hold & en;
    assign done     = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_ff <= 1'b0;
        end else begin
            en_ff <= en;
        end
    end

    // Abort beats hold, hold beats counting; the count never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            shadow <= '0;
            mode_q <= MODE_ONE_SHOT;
        end else if (state == ST_IDLE) begin
            if (start) begin
                cnt    <= load;
                shadow <= load;
                mode_q <= mode;
                state  <= ST_RUN;
            end
        end else begin
            if (!en) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (!hold) begin
                if (!cnt_zero) begin
                    cnt <= cnt - CNT_ONE;
                end else if (mode_q == MODE_PERIODIC) begin
                    cnt <= shadow;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: rtl/multi_chan_timer.sv
// CH_NUM independent down-counting timers with an optional sticky interrupt,
// built only when TIMER_IRQ_EN is defined (otherwise status/irq read as 0).
module multi_chan_timer
    import multi_chan_timer_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int CH_NUM = 4
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst_b,
    input  logic [CH_NUM-1:0]       timer_en,
    input  logic [CH_NUM-1:0]       timer_mode,
    input  logic [CH_NUM-1:0]       timer_hold,
    input  logic [CH_NUM*CNT_W-1:0] timer_load,
    input  logic [CH_NUM-1:0]       timer_irq_clr,
    output logic [CH_NUM*CNT_W-1:0] timer_cnt,
    output logic [CH_NUM-1:0]       timer_done,
    output logic [CH_NUM-1:0]       timer_expire,
    output logic [CH_NUM-1:0]       timer_status,
    output logic                    timer_irq
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        multi_chan_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (cpu_clk),
            .rst_n  (cpu_rst_b),
            .en     (timer_en[i]),
            .mode   (timer_mode[i]),
            .hold   (timer_hold[i]),
            .load   (timer_load[i*CNT_W +: CNT_W]),
            .cnt    (timer_cnt[i*CNT_W +: CNT_W]),
            .done   (timer_done[i]),
            .expire (timer_expire[i])
        );
    end

`ifdef TIMER_IRQ_EN
    // A new expire in the same cycle as a clear keeps the flag set.
    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            timer_status <= '0;
            timer_irq    <= 1'b0;
        end else begin
            timer_status <= (timer_status & ~timer_irq_clr) | timer_expire;
            timer_irq    <= |timer_status;
        end
    end
`else
    logic unused_irq_clr;

    assign unused_irq_clr = ^timer_irq_clr;
    assign timer_status   = '0;
    assign timer_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_multi_chan_timer.sv
// Directed self-checking bench for multi_chan_timer: a 4x32 instance for the
// channel behaviours plus a 1x8 instance for the full-range no-wrap case.
module tb_multi_chan_timer;

`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic         cpu_clk = 1'b0;
    logic         cpu_rst_b;
    logic [3:0]   timer_en, timer_mode, timer_hold, timer_irq_clr;
    logic [127:0] timer_load;
    logic [127:0] timer_cnt;
    logic [3:0]   timer_done, timer_expire, timer_status;
    logic         timer_irq;

    logic         en8, mode8, hold8, clr8;
    logic [7:0]   load8, cnt8;
    logic         done8, expire8, status8, irq8;

    int checks   = 0;
    int failures = 0;

    multi_chan_timer #(.CNT_W(32), .CH_NUM(4)) u_dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst_b     (cpu_rst_b),
        .timer_en      (timer_en),
        .timer_mode    (timer_mode),
        .timer_hold    (timer_hold),
        .timer_load    (timer_load),
        .timer_irq_clr (timer_irq_clr),
        .timer_cnt     (timer_cnt),
        .timer_done    (timer_done),
        .timer_expire  (timer_expire),
        .timer_status  (timer_status),
        .timer_irq     (timer_irq)
    );

    multi_chan_timer #(.CNT_W(8), .CH_NUM(1)) u_dut8 (
        .cpu_clk       (cpu_clk),
        .cpu_rst_b     (cpu_rst_b),
        .timer_en      (en8),
        .timer_mode    (mode8),
        .timer_hold    (hold8),
        .timer_load    (load8),
        .timer_irq_clr (clr8),
        .timer_cnt     (cnt8),
        .timer_done    (done8),
        .timer_expire  (expire8),
        .timer_status  (status8),
        .timer_irq     (irq8)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return timer_cnt[ch*32 +: 32];
    endfunction

    initial begin
        int first;
        int pulses;

        cpu_rst_b     = 1'b0;
        timer_en      = '0;
        timer_mode    = '0;
        timer_hold    = '0;
        timer_irq_clr = '0;
        timer_load    = '0;
        en8 = 1'b0; mode8 = 1'b0; hold8 = 1'b0; clr8 = 1'b0; load8 = '0;

        // Reset state
        #12;
        for (int i = 0; i < 4; i++) check_output("rst_cnt", cnt_of(i), 0);
        check_output("rst_done", timer_done, 4'hF);
        check_output("rst_expire", timer_expire, 4'h0);
        check_output("rst_status", timer_status, 4'h0);
        check_output("rst_irq", timer_irq, 1'b0);
        cpu_rst_b = 1'b1;
        tick();

        // Ch0 one-shot, load 5
        timer_load[31:0] = 32'd5;
        timer_mode[0]    = 1'b0;
        timer_en[0]      = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            check_output("os_cnt", cnt_of(0), (j <= 5) ? 5 - j : 0);
            check_output("os_expire", timer_expire[0], j == 5);
            check_output("os_done", timer_done[0], j >= 6);
            tick();
        end
        timer_en[0] = 1'b0;

        // Ch1 periodic, load 3, load changes mid-run
        timer_load[63:32] = 32'd3;
        timer_mode[1]     = 1'b1;
        timer_en[1]       = 1'b1;
        tick();
        for (int j = 0; j < 20; j++) begin
            check_output("per_cnt", cnt_of(1), 3 - (j % 4));
            check_output("per_expire", timer_expire[1], (j % 4) == 3);
            check_output("per_done", timer_done[1], 1'b0);
            if (j == 8) timer_load[63:32] = 32'd9;
            tick();
        end
        timer_en[1] = 1'b0;
        tick();
        check_output("per_abort_done", timer_done[1], 1'b1);
        check_output("per_abort_cnt", cnt_of(1), 0);

        // Ch2 load 10, three hold cycles delay expiry by three
        timer_load[95:64] = 32'd10;
        timer_mode[2]     = 1'b0;
        timer_en[2]       = 1'b1;
        tick();
        for (int j = 0; j < 15; j++) begin
            check_output("hold_cnt", cnt_of(2),
                         (j < 3) ? 10 - j : (j <= 5) ? 8 : (j <= 13) ? 13 - j : 0);
            check_output("hold_expire", timer_expire[2], j == 13);
            check_output("hold_done", timer_done[2], j >= 14);
            if (j == 2) timer_hold[2] = 1'b1;
            if (j == 5) timer_hold[2] = 1'b0;
            tick();
        end
        timer_en[2] = 1'b0;
        tick();

        // Ch2 restart, abort at cnt=4
        timer_en[2] = 1'b1;
        tick();
        for (int j = 0; j <= 6; j++) begin
            check_output("abort_cnt", cnt_of(2), 10 - j);
            if (j < 6) tick();
        end
        timer_en[2] = 1'b0;
        tick();
        check_output("abort_done", timer_done[2], 1'b1);
        check_output("abort_cnt0", cnt_of(2), 0);
        check_output("abort_expire", timer_expire[2], 1'b0);
        tick();
        check_output("abort_expire_late", timer_expire[2], 1'b0);

        // Clear all sticky flags
        timer_irq_clr = 4'hF;
        tick();
        timer_irq_clr = 4'h0;
        tick();
        check_output("clr_status", timer_status, 4'h0);
        check_output("clr_irq", timer_irq, 1'b0);

        // Ch3 one-shot load 0, status/irq latency
        timer_load[127:96] = 32'd0;
        timer_mode[3]      = 1'b0;
        timer_en[3]        = 1'b1;
        tick();
        check_output("z_cnt", cnt_of(3), 0);
        check_output("z_expire", timer_expire[3], 1'b1);
        check_output("z_done", timer_done[3], 1'b0);
        check_output("z_status0", timer_status[3], 1'b0);
        tick();
        check_output("z_expire_once", timer_expire[3], 1'b0);
        check_output("z_done_after", timer_done[3], 1'b1);
        check_output("z_status1", timer_status[3], IRQ_ON);
        check_output("z_irq_lag", timer_irq, 1'b0);
        tick();
        check_output("z_irq", timer_irq, IRQ_ON);
        check_output("z_status_sticky", timer_status[3], IRQ_ON);
        timer_en[3] = 1'b0;
        tick();

        // Ch3 periodic load 0: expire every cycle; clear vs set; hold masks
        timer_mode[3] = 1'b1;
        timer_en[3]   = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            check_output("pz_expire", timer_expire[3], 1'b1);
            check_output("pz_done", timer_done[3], 1'b0);
            tick();
        end
        timer_irq_clr[3] = 1'b1;
        tick();
        check_output("clr_set_wins", timer_status[3], IRQ_ON);
        timer_hold[3] = 1'b1;
        #1;
        check_output("hold_mask", timer_expire[3], 1'b0);
        tick();
        check_output("clr_status3", timer_status[3], 1'b0);
        check_output("hold_run", timer_done[3], 1'b0);
        timer_irq_clr[3] = 1'b0;
        tick();
        check_output("clr_irq3", timer_irq, 1'b0);
        timer_hold[3] = 1'b0;
        #1;
        check_output("unhold_expire", timer_expire[3], 1'b1);
        timer_en[3] = 1'b0;
        tick();
        check_output("pz_abort_done", timer_done[3], 1'b1);

        // 8-bit instance, load FF: expire 255 edges after start, no wrap
        load8 = 8'hFF;
        en8   = 1'b1;
        tick();
        check_output("w8_cnt_start", cnt8, 8'hFF);
        first  = -1;
        pulses = 0;
        for (int j = 0; j < 260; j++) begin
            if (expire8) begin
                pulses++;
                if (first < 0) first = j;
            end
            tick();
        end
        check_output("w8_expire_at", first, 255);
        check_output("w8_pulses", pulses, 1);
        check_output("w8_cnt_end", cnt8, 8'h00);
        check_output("w8_done", done8, 1'b1);
        en8 = 1'b0;

        // Asynchronous reset mid-count on all channels
        timer_load = {32'd2, 32'd20, 32'd20, 32'd20};
        timer_mode = 4'b1000;
        timer_en   = 4'hF;
        tick();
        repeat (6) tick();
        check_output("pre_rst_done", timer_done, 4'h0);
        check_output("pre_rst_irq", timer_irq, IRQ_ON);
        #2;
        cpu_rst_b = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check_output("arst_cnt", cnt_of(i), 0);
        check_output("arst_done", timer_done, 4'hF);
        check_output("arst_expire", timer_expire, 4'h0);
        check_output("arst_status", timer_status, 4'h0);
        check_output("arst_irq", timer_irq, 1'b0);
        timer_en = 4'h0;
        #1;
        cpu_rst_b = 1'b1;
        tick();

        // Normal start after reset release
        timer_mode       = 4'h0;
        timer_load[31:0] = 32'd2;
        timer_en[0]      = 1'b1;
        tick();
        check_output("post_cnt", cnt_of(0), 2);
        tick();
        tick();
        check_output("post_expire", timer_expire[0], 1'b1);
        tick();
        check_output("post_done", timer_done[0], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_chan_timer.md
# multi_chan_timer

Parametrised multi-channel down-counting timer for the smart_run logical common library, generalising the single 32-bit one-shot FIFO delay counter. Each of CH_NUM independent channels loads a CNT_W-bit value on the rising edge of its enable and counts down to zero. At zero a channel either stops (one-shot) or reloads from a latched shadow value (periodic). Testbench FIFO/AXI models use it for programmable delays and periodic event generation, with an optional aggregated sticky interrupt.

## Interface
- CNT_W, 32, counter width per channel (≥2)
- CH_NUM, 4, number of channels (≥1)
- cpu_clk  input  1  single clock, all state on posedge
- cpu_rst_b  input  1  asynchronous active-low reset
- timer_en  input  CH_NUM  per-channel enable; rising edge starts, low level aborts
- timer_mode  input  CH_NUM  0 = one-shot, 1 = periodic; sampled at start
- timer_hold  input  CH_NUM  1 = freeze count, mask expire
- timer_load  input  CH_NUM*CNT_W  load value, channel i at [i*CNT_W +: CNT_W]
- timer_irq_clr  input  CH_NUM  clear sticky status bit
- timer_cnt  output  CH_NUM*CNT_W  current count
- timer_done  output  CH_NUM  1 when channel idle
- timer_expire  output  CH_NUM  one-cycle pulse on reaching zero
- timer_status  output  CH_NUM  sticky expire flags
- timer_irq  output  1  OR of timer_status, registered

## Operation
- Per channel FSM: IDLE, RUN. Reset: IDLE, cnt=0, shadow=0, mode latch=0, en_ff=0, status=0, irq=0; hence timer_done=1 and timer_expire=0.
- start = timer_en & !en_ff. In IDLE, start: cnt<=load, shadow<=load, mode latch<=timer_mode, state<=RUN.
- RUN, timer_en low: abort. Go to IDLE, cnt<=0, no expire. Abort has priority over all other RUN actions.
- RUN, timer_hold=1: cnt frozen, expire masked.
- RUN, hold=0, cnt≠0: cnt<=cnt−1.
- RUN, hold=0, cnt==0: timer_expire=1 this cycle. One-shot: go to IDLE. Periodic: cnt<=shadow, stay RUN.
- timer_expire = (state==RUN) & (cnt==0) & !hold & timer_en. Combinational from registers and inputs.
- timer_done = (state==IDLE).
- Arithmetic is CNT_W-bit unsigned. Count stops at 0 and never wraps. Maximum load is 2^CNT_W−1.
- Load 0: expire in the first RUN cycle. A periodic channel with load 0 expires every cycle.
- timer_load and timer_mode are ignored outside the start cycle. Periodic reload uses only shadow.
- Channels are fully independent and share no state.

## Timing
- Start sampled at edge k. One-shot with load L: timer_expire high in the cycle after edge k+L, timer_done high after edge k+L+1.
- Periodic period = L+1 cycles between expire pulses, plus 1 cycle for each hold cycle.
- Abort takes effect at the next edge. timer_done rises one cycle after timer_en falls.
- Re-start needs timer_en low for at least one sampled edge.
- Reset asserted mid-count returns every output to its reset value immediately (asynchronous).

## Configuration
- TIMER_IRQ_EN defined: status[i] is set on timer_expire[i] and cleared on timer_irq_clr[i]. If set and clear occur in the same cycle, set wins. timer_irq <= |status, giving 1 cycle latency after status.
- TIMER_IRQ_EN undefined: the status/irq logic is not built. timer_status and timer_irq are tied to 0 and timer_irq_clr is ignored. Ports are unchanged.

## Structure
- A shared include/package holds the FSM state encoding (IDLE=1'b0, RUN=1'b1) and mode constants (ONE_SHOT=0, PERIODIC=1).
- Sub-module multi_chan_timer_ch implements one channel: FSM, cnt, shadow, en_ff, expire.
- The top generates CH_NUM instances, slices timer_load and timer_cnt, and contains the TIMER_IRQ_EN logic.

## Test plan
- CH_NUM=4, CNT_W=32. Ch0 one-shot, load 5, rising en → expire exactly 6 cycles after the start edge; done returns; cnt stays 0.
- Ch1 periodic, load 3 → expire every 4 cycles for 5 periods. Change timer_load to 9 mid-run → period stays 4.
- Ch2 load 10, hold high for 3 cycles mid-count → expire delayed by exactly 3 cycles. Drop en at cnt=4 → no expire, done=1 next cycle.
- Load 0 one-shot → single expire in the first RUN cycle. CNT_W=8, load 8'hFF → expire after 256 cycles, no wrap.
- TIMER_IRQ_EN defined: expire sets status and irq rises 1 cycle later. Clear coincident with a new expire → status stays 1. Build without the macro → irq and status remain 0.
- Assert cpu_rst_b low mid-count on all channels → cnt=0, done=1, status=0, irq=0 immediately. A new start after release behaves normally.
